p256_digit_serial_reducer: RTL
==============================

# p256_digit_serial_reducer

Next-generation P-256 modular reducer. It takes a 512-bit product and returns the fully reduced residue in [0, p), with p = 2^256 − 2^224 + 2^192 + 2^96 − 1. It replaces the single-shot 32-bit-limb fold/carry reducer with a digit-serial engine of configurable adder width, a start/busy/done handshake, and final correction to a canonical result. It sits between the squarer/multiplier output and the field-arithmetic sequencer.

## Interface
- ADD_W, 64: digit width of the shared add/sub slice; legal values 32, 64, 128, 256. N_DIG = 256/ADD_W.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global clock enable; when 0 all state, including outputs, holds
- start  in  1  request; sampled only when ena=1 and busy=0
- a_high  in  256  upper half of operand A (32-bit words A15..A8)
- a_low  in  256  lower half of operand A (A7..A0)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result is valid from this cycle on
- result  out  256  A mod p, held until the next done

## Operation
- States: IDLE, LOAD, PASS, CORR, TRIAL, FIX, DONE.
- IDLE: busy=0. start=1 captures a_high/a_low into an operand register and moves to LOAD.
- LOAD: acc ← T = (A7..A0); ovf ← 0. ovf is a 5-bit signed count of the multiples of 2^256 above acc.
- PASS: fixed term sequence +S1, +S1, +S2, +S2, +S3, +S4, −D1, −D2, −D3, −D4. Words are listed MSW first:
  - S1 = (A15,A14,A13,A12,A11,0,0,0)
  - S2 = (0,A15,A14,A13,A12,0,0,0)
  - S3 = (A15,A14,0,0,0,A10,A9,A8)
  - S4 = (A8,A13,A15,A14,A13,A11,A10,A9)
  - D1 = (A10,A8,0,0,0,A13,A12,A11)
  - D2 = (A11,A9,0,0,A15,A14,A13,A12)
  - D3 = (A12,0,A10,A9,A8,A15,A14,A13)
  - D4 = (A13,0,A11,A10,A9,0,A15,A14)
- Each pass takes N_DIG cycles, LSB digit first. Carry/borrow is registered between digits and cleared at pass start.
- At the end of each pass, ovf += final carry (add pass) or ovf −= final borrow (sub pass).
- After all passes, ovf lies in [−4, 6].
- CORR (one pass per visit):
  - ovf < 0: add p.
  - ovf > 0: subtract p.
  - ovf = 0: go to TRIAL.
- TRIAL: subtract p.
  - Final borrow = 0: acc was ≥ p; go to DONE.
  - Final borrow = 1: go to FIX.
- FIX: add p, then DONE.
- DONE: result ← acc, done=1 for one cycle, then IDLE. busy drops in the same cycle done rises.
- start while busy=1 is ignored; no queueing.
- Any operand in [0, 2^512) is legal. The result is always < p.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, acc/ovf/carry=0.
- Handshake latency, start-accept cycle = cycle 0:
  - LOAD: 1 cycle.
  - Term passes: 10·N_DIG cycles.
  - Correction: k·N_DIG cycles, with k = |ovf| + 1 (+1 if FIX); k ≤ 9.
  - DONE: 1 cycle.
- Worst case with ADD_W=64: 1 + 40 + 36 + 1 = 78 cycles.
- ena=0 freezes every register, including the done pulse, which then stretches. Latency counts only ena=1 cycles.
- rst_n asserted mid-operation: immediate return to reset values, with no done. The next start begins cleanly.
- Back-to-back: start in the cycle after done is accepted.

## Structure
- Package p256_pkg: P256 constant (256-bit), ADD_W legality check, state encoding, and the term table as a function term_word(term_id, word_idx) returning the A index or zero.
- Sub-module p256_digit_addsub: ADD_W-bit add/sub.
  - Inputs: x, y, sub, cin.
  - Outputs: s, cout (borrow when sub=1).
  - Single instance shared by all passes.
- Digit and word selection is a mux over acc/operand indexed by the digit counter.

## Test plan
- a_high=0, a_low=0 → result 0; done at the fixed no-correction latency, busy high throughout.
- a_high=0, a_low=p+5 → result 5. Exercises the TRIAL path with borrow = 0.
- a_high=1, a_low=0 → result 0x00000000fffffffeffffffffffffffffffffffff000000000000000000000001.
- A=(p−1)^2 → result 1. A=2^512−1 → result matches the reference model. Repeat for ADD_W = 32, 64, 128, 256.
- Reset and control:
  - rst_n pulsed low mid-PASS → outputs at reset values, no done; the next start with A=p yields 0.
  - start held high across busy → exactly one done per accepted start.
  - ena toggled randomly → same results as with ena held high.
- Random 10k operands vs golden model → exact match; latency within bounds for each ADD_W.

Source files
------------

// File: rtl/p256_pkg.sv
// Shared constants, state encoding and operand-word selection table for the P-256 reducer.
// No logic of its own: constants and pure functions only.
// No flow control: consumed at elaboration by the reducer and its add/sub slice.
//
// Contents:
//   P256        - the field prime p = 2^256 - 2^224 + 2^192 + 2^96 - 1
//   state_t     - reducer FSM encoding
//   add_w_legal - true for the supported add/sub slice widths
//   term_word   - for term_id 0..9 (+S1,+S1,+S2,+S2,+S3,+S4,-D1,-D2,-D3,-D4) and a
//                 word index 0..7 (LSW first) returns {zero, A index}. A set zero
//                 bit means the word is a constant 0.
package p256_pkg;

  localparam logic [255:0] P256 =
    256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

  localparam logic [3:0] N_TERMS        = 4'd10;
  localparam logic [3:0] FIRST_SUB_TERM = 4'd6;

  // Encoded "word is zero" entry of the term table.
  localparam logic [4:0] WZ = 5'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PASS,
    ST_CORR,
    ST_TRIAL,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic bit add_w_legal(input int w);
    return (w == 32) || (w == 64) || (w == 128) || (w == 256);
  endfunction

  // Each row is packed MSW first: {w7, w6, ..., w0}, five bits per word.
  function automatic logic [4:0] term_word(input logic [3:0] term_id,
                                           input logic [2:0] word_idx);
    logic [39:0] row;
    case (term_id)
      4'd0, 4'd1: row = {5'd15, 5'd14, 5'd13, 5'd12, 5'd11, WZ, WZ, WZ};           // S1
      4'd2, 4'd3: row = {WZ, 5'd15, 5'd14, 5'd13, 5'd12, WZ, WZ, WZ};              // S2
      4'd4:       row = {5'd15, 5'd14, WZ, WZ, WZ, 5'd10, 5'd9, 5'd8};             // S3
      4'd5:       row = {5'd8, 5'd13, 5'd15, 5'd14, 5'd13, 5'd11, 5'd10, 5'd9};    // S4
      4'd6:       row = {5'd10, 5'd8, WZ, WZ, WZ, 5'd13, 5'd12, 5'd11};            // D1
      4'd7:       row = {5'd11, 5'd9, WZ, WZ, 5'd15, 5'd14, 5'd13, 5'd12};         // D2
      4'd8:       row = {5'd12, WZ, 5'd10, 5'd9, 5'd8, 5'd15, 5'd14, 5'd13};       // D3
      4'd9:       row = {5'd13, WZ, 5'd11, 5'd10, 5'd9, WZ, 5'd15, 5'd14};         // D4
      default:    row = {8{WZ}};
    endcase
    return row[word_idx*5 +: 5];
  endfunction

endpackage

// File: rtl/p256_digit_addsub.sv
// ADD_W-bit add/subtract slice with carry/borrow in and out.
// Latency: combinational.
// No flow control: operands are consumed in the same cycle they are presented.
//
// Ports:
//   x, y  - digit operands
//   sub   - 0: s = x + y + cin, cout = carry; 1: s = x - y - cin, cout = borrow
//   cin   - carry in (borrow in when sub=1)
//   s     - digit result
//   cout  - carry out (borrow out when sub=1)
module p256_digit_addsub #(
  parameter int ADD_W = 64
) (
  input  logic [ADD_W-1:0] x,
  input  logic [ADD_W-1:0] y,
  input  logic             sub,
  input  logic             cin,
  output logic [ADD_W-1:0] s,
  output logic             cout
);

  logic [ADD_W:0]   sum;
  logic [ADD_W-1:0] y_eff;
  logic             c_eff;

  // x - y - b == x + ~y + ~b, and the adder's carry out is the inverse of the borrow.
  always_comb begin
    y_eff = sub ? ~y : y;
    c_eff = sub ? ~cin : cin;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{ADD_W{1'b0}}, c_eff};
    s     = sum[ADD_W-1:0];
    cout  = sub ? ~sum[ADD_W] : sum[ADD_W];
  end

endmodule

// File: rtl/p256_digit_serial_reducer.sv
// Digit-serial P-256 reducer: 512-bit product in, canonical residue in [0, p) out.
// Latency: 2 + (10 + k) * (256/ADD_W) enabled cycles from start accept to done, k <= 9.
// Backpressure: start is taken only in IDLE with ena=1; ena=0 freezes all state.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   ena             - global clock enable
//   start           - request, accepted in IDLE only
//   a_high, a_low   - operand words A15..A8 and A7..A0
//   busy            - operation in flight (drops in the done cycle)
//   done            - result valid pulse, stretched while ena=0
//   result          - A mod p, held until the next done
module p256_digit_serial_reducer
  import p256_pkg::*;
#(
  parameter int ADD_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [255:0] a_high,
  input  logic [255:0] a_low,
  output logic         busy,
  output logic         done,
  output logic [255:0] result
);

  localparam int N_DIG = 256 / ADD_W;
  localparam int DIG_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(N_DIG - 1);

  if (!add_w_legal(ADD_W)) begin : g_add_w_check
    $error("p256_digit_serial_reducer: ADD_W must be 32, 64, 128 or 256");
  end

  state_t state_q, state_d;

  logic [511:0]       op_q;
  logic [255:0]       acc_q;
  logic [255:0]       result_q;
  logic signed [4:0]  ovf_q;     // signed count of 2^256 multiples above acc
  logic               carry_q;
  logic [DIG_W-1:0]   dig_q;
  logic [3:0]         term_q;

  logic [255:0]       term_vec;
  logic [255:0]       p_vec;
  logic [4:0]         word_sel;
  logic [ADD_W-1:0]   x_dig;
  logic [ADD_W-1:0]   y_dig;
  logic [ADD_W-1:0]   s_dig;
  logic               sub_op;
  logic               cout;
  logic signed [4:0]  ovf_nxt;
  logic               last_dig;
  logic               last_term;

  assign p_vec     = P256;
  assign last_dig  = (dig_q == LAST_DIG);
  assign last_term = (term_q == N_TERMS - 4'd1);

  // Assemble the current term from operand words; only the selected digit is used.
  always_comb begin
    term_vec = '0;
    word_sel = '0;
    for (int w = 0; w < 8; w++) begin
      word_sel = term_word(term_q, 3'(w));
      if (!word_sel[4]) begin
        term_vec[32*w +: 32] = op_q[32*word_sel[3:0] +: 32];
      end
    end
  end

  always_comb begin
    x_dig = acc_q[dig_q*ADD_W +: ADD_W];
    y_dig = (state_q == ST_PASS) ? term_vec[dig_q*ADD_W +: ADD_W]
                                 : p_vec[dig_q*ADD_W +: ADD_W];
  end

  // CORR is only entered with ovf != 0, so the sign bit alone picks add/subtract.
  always_comb begin
    sub_op = 1'b0;
    case (state_q)
      ST_PASS:  sub_op = (term_q >= FIRST_SUB_TERM);
      ST_CORR:  sub_op = ~ovf_q[4];
      ST_TRIAL: sub_op = 1'b1;
      default:  sub_op = 1'b0;
    endcase
  end

  p256_digit_addsub #(
    .ADD_W (ADD_W)
  ) u_addsub (
    .x    (x_dig),
    .y    (y_dig),
    .sub  (sub_op),
    .cin  (carry_q),
    .s    (s_dig),
    .cout (cout)
  );

  assign ovf_nxt = sub_op ? (ovf_q - $signed({4'b0000, cout}))
                          : (ovf_q + $signed({4'b0000, cout}));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_PASS;
      ST_PASS:  if (last_dig && last_term) state_d = (ovf_nxt == 5'sd0) ? ST_TRIAL : ST_CORR;
      ST_CORR:  if (last_dig) state_d = (ovf_nxt == 5'sd0) ? ST_TRIAL : ST_CORR;
      // A borrow out of acc - p means acc was already below p: undo it in FIX.
      ST_TRIAL: if (last_dig) state_d = cout ? ST_FIX : ST_DONE;
      ST_FIX:   if (last_dig) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs. In the done cycle the final acc is already complete, so it is
  // presented directly while result_q catches up on the same edge that leaves DONE.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    result = result_q;
    case (state_q)
      ST_IDLE: ;
      ST_DONE: begin
        done   = 1'b1;
        result = acc_q;
      end
      default: busy = 1'b1;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= '0;
      carry_q  <= 1'b0;
      dig_q    <= '0;
      term_q   <= '0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start) op_q <= {a_high, a_low};
        end
        ST_LOAD: begin
          acc_q   <= op_q[255:0];
          ovf_q   <= '0;
          carry_q <= 1'b0;
          dig_q   <= '0;
          term_q  <= '0;
        end
        ST_PASS, ST_CORR, ST_TRIAL, ST_FIX: begin
          acc_q[dig_q*ADD_W +: ADD_W] <= s_dig;
          if (last_dig) begin
            carry_q <= 1'b0;
            dig_q   <= '0;
            if (state_q == ST_PASS || state_q == ST_CORR) ovf_q <= ovf_nxt;
            if (state_q == ST_PASS) term_q <= term_q + 4'd1;
          end else begin
            carry_q <= cout;
            dig_q   <= dig_q + 1'b1;
          end
        end
        ST_DONE: result_q <= acc_q;
        default: ;
      endcase
    end
  end

endmodule
